// File: rtl/spu_issue_ctrl_pkg.sv
// Shared definitions for the SPU REG->EX issue controller.
// Holds the register-file geometry, the producer-latency field width, the
// readUse bit positions, the issue FSM state type and a helper that turns a
// producer latency into the scoreboard countdown value.
package spu_pipe_pkg;

  localparam int NUM_REGS = 128;
  localparam int REG_AW   = 7;
  localparam int LAT_W    = 3;
  localparam int CNT_W    = 32;

  // Bit positions inside readUse_REGx.
  localparam int USE_RA = 0;
  localparam int USE_RB = 1;
  localparam int USE_RC = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [LAT_W-1:0]  lat_t;

  // PAIR: both REG slots are live. SPLIT: slot 1 already went, slot 2 waits.
  typedef enum logic [0:0] {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } issue_state_t;

  // A producer of latency L keeps its destination busy for L-1 more cycles
  // after issue. Latency 0 is treated as 1 (immediately forwardable).
  function automatic lat_t lat_to_cnt(lat_t lat);
    return (lat == '0) ? '0 : lat - lat_t'(1);
  endfunction

endpackage

// File: rtl/spu_issue_ctrl_if.sv
// REG-stage instruction pair and issue handshake.
// master: the pipeline side that presents the REG-stage pair and flush/freeze
//         and receives the per-slot issue decision and the REG stall.
// slave : the issue controller.
// Handshake: a slot whose valid_REGx is high advances into EX on a clock edge
// exactly when issue_EX<x> is high in that cycle; otherwise the REG stage holds
// it (stall_REG) and a bubble goes down the pipe in its place.
interface spu_issue_ctrl_if;
  import spu_pipe_pkg::*;

  logic       valid_REG1;
  logic       valid_REG2;
  logic       regWriteEnable_REG1;
  logic       regWriteEnable_REG2;
  reg_addr_t  writeRegister_REG1;
  reg_addr_t  writeRegister_REG2;
  reg_addr_t  readRegisterRA_REG1;
  reg_addr_t  readRegisterRB_REG1;
  reg_addr_t  readRegisterRC_REG1;
  reg_addr_t  readRegisterRA_REG2;
  reg_addr_t  readRegisterRB_REG2;
  reg_addr_t  readRegisterRC_REG2;
  logic [2:0] readUse_REG1;
  logic [2:0] readUse_REG2;
  lat_t       latency_REG1;
  lat_t       latency_REG2;
  logic       flush;
  logic       stall_ext;
  logic       issue_EX1;
  logic       issue_EX2;
  logic       stall_REG;

  modport master (
    output valid_REG1, valid_REG2, regWriteEnable_REG1, regWriteEnable_REG2,
           writeRegister_REG1, writeRegister_REG2,
           readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRC_REG1,
           readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRC_REG2,
           readUse_REG1, readUse_REG2, latency_REG1, latency_REG2,
           flush, stall_ext,
    input  issue_EX1, issue_EX2, stall_REG
  );

  modport slave (
    input  valid_REG1, valid_REG2, regWriteEnable_REG1, regWriteEnable_REG2,
           writeRegister_REG1, writeRegister_REG2,
           readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRC_REG1,
           readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRC_REG2,
           readUse_REG1, readUse_REG2, latency_REG1, latency_REG2,
           flush, stall_ext,
    output issue_EX1, issue_EX2, stall_REG
  );

endinterface

// File: rtl/spu_scoreboard.sv
// Per-register latency scoreboard.
// Each architectural register owns a countdown; nonzero means the in-flight
// result is not yet forwardable.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (clears all counts)
//   hold              freeze every counter (downstream stall)
//   rd_addr/rd_cnt    8 combinational read ports (6 sources, 2 destinations)
//   ld_en/addr/val    2 load ports; a load wins over the decrement
module spu_scoreboard
  import spu_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      hold,
  input  reg_addr_t rd_addr [8],
  output lat_t      rd_cnt  [8],
  input  logic      ld_en   [2],
  input  reg_addr_t ld_addr [2],
  input  lat_t      ld_val  [2]
);

  lat_t cnt_q [NUM_REGS];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rd_cnt[i] = cnt_q[rd_addr[i]];
    end
  end

  // The two load ports never target the same register in one cycle (the
  // controller splits such pairs), so the port-0 priority is only a tiebreak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else if (!hold) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (ld_en[0] && (ld_addr[0] == reg_addr_t'(r))) begin
          cnt_q[r] <= ld_val[0];
        end else if (ld_en[1] && (ld_addr[1] == reg_addr_t'(r))) begin
          cnt_q[r] <= ld_val[1];
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - lat_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spu_issue_ctrl.sv
// Dual-issue hazard and issue controller at the SPU REG->EX boundary.
// Decides per cycle whether each REG-stage slot advances into EX, splits a
// pair with an internal dependency, and stalls the front end otherwise.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   bus           REG-stage pair, flush/stall_ext in; issue_EX1/2, stall_REG out
//   split_active  high while the controller is in SPLIT (slot 1 already gone)
//   stallCycles   saturating count of cycles with stall_REG high
module spu_issue_ctrl
  import spu_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  spu_issue_ctrl_if.slave   bus,
  output logic              split_active,
  output logic [CNT_W-1:0]  stallCycles
);

  issue_state_t state_q, state_d;

  reg_addr_t rd_addr [8];
  lat_t      rd_cnt  [8];
  logic      ld_en   [2];
  reg_addr_t ld_addr [2];
  lat_t      ld_val  [2];

  logic v1, v2;
  logic src_haz1, src_haz2, waw_haz1, waw_haz2, haz1, haz2;
  logic src2_hits_dest1, intra;
  logic issue1, issue2, stall_reg;
  lat_t busy1, busy2;

  // Read port map: 0..2 slot-1 sources, 3..5 slot-2 sources, 6/7 destinations.
  always_comb begin
    rd_addr[0] = bus.readRegisterRA_REG1;
    rd_addr[1] = bus.readRegisterRB_REG1;
    rd_addr[2] = bus.readRegisterRC_REG1;
    rd_addr[3] = bus.readRegisterRA_REG2;
    rd_addr[4] = bus.readRegisterRB_REG2;
    rd_addr[5] = bus.readRegisterRC_REG2;
    rd_addr[6] = bus.writeRegister_REG1;
    rd_addr[7] = bus.writeRegister_REG2;
  end

  spu_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .hold    (bus.stall_ext),
    .rd_addr (rd_addr),
    .rd_cnt  (rd_cnt),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_val  (ld_val)
  );

  always_comb begin
    // In SPLIT the slot-1 instruction has already left; ignore what sits there.
    v1 = bus.valid_REG1 && (state_q == PAIR);
    v2 = bus.valid_REG2;

    busy1 = lat_to_cnt(bus.latency_REG1);
    busy2 = lat_to_cnt(bus.latency_REG2);

    src_haz1 = (bus.readUse_REG1[USE_RA] && (rd_cnt[0] != '0)) ||
               (bus.readUse_REG1[USE_RB] && (rd_cnt[1] != '0)) ||
               (bus.readUse_REG1[USE_RC] && (rd_cnt[2] != '0));
    src_haz2 = (bus.readUse_REG2[USE_RA] && (rd_cnt[3] != '0)) ||
               (bus.readUse_REG2[USE_RB] && (rd_cnt[4] != '0)) ||
               (bus.readUse_REG2[USE_RC] && (rd_cnt[5] != '0));

    // An older write that would land after ours must not overwrite it.
    waw_haz1 = bus.regWriteEnable_REG1 && (rd_cnt[6] > busy1);
    waw_haz2 = bus.regWriteEnable_REG2 && (rd_cnt[7] > busy2);

    haz1 = src_haz1 || waw_haz1;
    haz2 = src_haz2 || waw_haz2;

    src2_hits_dest1 =
      (bus.readUse_REG2[USE_RA] && (bus.readRegisterRA_REG2 == bus.writeRegister_REG1)) ||
      (bus.readUse_REG2[USE_RB] && (bus.readRegisterRB_REG2 == bus.writeRegister_REG1)) ||
      (bus.readUse_REG2[USE_RC] && (bus.readRegisterRC_REG2 == bus.writeRegister_REG1));

    intra = v1 && bus.regWriteEnable_REG1 &&
            (src2_hits_dest1 ||
             (bus.regWriteEnable_REG2 && (bus.writeRegister_REG2 == bus.writeRegister_REG1)));

    issue1 = !reset && v1 && !haz1 && !bus.stall_ext && !bus.flush;
    // Slot 2 never overtakes a live slot 1.
    issue2 = !reset && v2 && !haz2 && !intra && (issue1 || !v1) &&
             !bus.stall_ext && !bus.flush;

    stall_reg = !reset && !bus.flush && ((v1 && !issue1) || (v2 && !issue2));

    ld_en[0]   = issue1 && bus.regWriteEnable_REG1;
    ld_addr[0] = bus.writeRegister_REG1;
    ld_val[0]  = busy1;
    ld_en[1]   = issue2 && bus.regWriteEnable_REG2;
    ld_addr[1] = bus.writeRegister_REG2;
    ld_val[1]  = busy2;
  end

  assign bus.issue_EX1 = issue1;
  assign bus.issue_EX2 = issue2;
  assign bus.stall_REG = stall_reg;
  assign split_active  = (state_q == SPLIT);

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = PAIR;
    end else begin
      case (state_q)
        PAIR:    if (issue1 && v2 && !issue2) state_d = SPLIT;
        SPLIT:   if (issue2)                  state_d = PAIR;
        default:                              state_d = PAIR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PAIR;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (stall_reg && !(&stallCycles)) begin
      stallCycles <= stallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Bench for spu_issue_ctrl: directed scenarios followed by randomized pairs,
// all checked against a ready-time reference model.
module tb_spu_issue_ctrl;
  import spu_pipe_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spu_issue_ctrl_if bus ();
  logic             split_active;
  logic [CNT_W-1:0] stallCycles;

  spu_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .split_active (split_active),
    .stallCycles  (stallCycles)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time advances only on edges without stall_ext. A register is forwardable
  // once the advance time reaches m_ready[r] (issue time + latency).
  longint unsigned m_ready [NUM_REGS];
  longint unsigned m_t;
  bit              m_split;
  longint unsigned m_stalls;
  bit              e1, e2, es;
  logic [2:0]      exp_q [$];
  logic            obs_i1, obs_i2, obs_s;

  function automatic int eff_lat(lat_t l);
    return (l == 0) ? 1 : int'(l);
  endfunction

  function automatic bit slot_blocked(logic [2:0] u, reg_addr_t a, reg_addr_t b,
                                      reg_addr_t c, logic we, reg_addr_t d, lat_t l);
    bit blk = 1'b0;
    if (u[0] && m_ready[a] > m_t) blk = 1'b1;
    if (u[1] && m_ready[b] > m_t) blk = 1'b1;
    if (u[2] && m_ready[c] > m_t) blk = 1'b1;
    if (we && m_ready[d] > m_t + longint'(eff_lat(l)) - 1) blk = 1'b1;
    return blk;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) m_ready[r] = 0;
    m_t = 0;
    m_split = 1'b0;
    m_stalls = 0;
  endtask

  task automatic model_decide();
    bit v1, v2, h1, h2, dep;
    v1 = bus.valid_REG1 && !m_split;
    v2 = bus.valid_REG2;
    h1 = slot_blocked(bus.readUse_REG1, bus.readRegisterRA_REG1, bus.readRegisterRB_REG1,
                      bus.readRegisterRC_REG1, bus.regWriteEnable_REG1,
                      bus.writeRegister_REG1, bus.latency_REG1);
    h2 = slot_blocked(bus.readUse_REG2, bus.readRegisterRA_REG2, bus.readRegisterRB_REG2,
                      bus.readRegisterRC_REG2, bus.regWriteEnable_REG2,
                      bus.writeRegister_REG2, bus.latency_REG2);
    dep = v1 && bus.regWriteEnable_REG1 &&
          ((bus.readUse_REG2[0] && bus.readRegisterRA_REG2 == bus.writeRegister_REG1) ||
           (bus.readUse_REG2[1] && bus.readRegisterRB_REG2 == bus.writeRegister_REG1) ||
           (bus.readUse_REG2[2] && bus.readRegisterRC_REG2 == bus.writeRegister_REG1) ||
           (bus.regWriteEnable_REG2 && bus.writeRegister_REG2 == bus.writeRegister_REG1));
    e1 = v1 && !h1 && !bus.stall_ext && !bus.flush;
    e2 = v2 && !h2 && !dep && (e1 || !v1) && !bus.stall_ext && !bus.flush;
    es = !bus.flush && ((v1 && !e1) || (v2 && !e2));
    exp_q.push_back({e1, e2, es});
  endtask

  task automatic model_commit();
    bit was_pending = !m_split && bus.valid_REG2;
    if (es && m_stalls != 64'hFFFF_FFFF) m_stalls++;
    if (!bus.stall_ext) begin
      if (e1 && bus.regWriteEnable_REG1)
        m_ready[bus.writeRegister_REG1] = m_t + longint'(eff_lat(bus.latency_REG1));
      if (e2 && bus.regWriteEnable_REG2)
        m_ready[bus.writeRegister_REG2] = m_t + longint'(eff_lat(bus.latency_REG2));
      m_t++;
    end
    if (bus.flush)                      m_split = 1'b0;
    else if (e1 && was_pending && !e2)  m_split = 1'b1;
    else if (m_split && e2)             m_split = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_slot1(logic v, logic we, reg_addr_t d, reg_addr_t ra,
                           reg_addr_t rb, reg_addr_t rc, logic [2:0] u, lat_t l);
    bus.valid_REG1 = v;  bus.regWriteEnable_REG1 = we; bus.writeRegister_REG1 = d;
    bus.readRegisterRA_REG1 = ra; bus.readRegisterRB_REG1 = rb;
    bus.readRegisterRC_REG1 = rc; bus.readUse_REG1 = u; bus.latency_REG1 = l;
  endtask

  task automatic set_slot2(logic v, logic we, reg_addr_t d, reg_addr_t ra,
                           reg_addr_t rb, reg_addr_t rc, logic [2:0] u, lat_t l);
    bus.valid_REG2 = v;  bus.regWriteEnable_REG2 = we; bus.writeRegister_REG2 = d;
    bus.readRegisterRA_REG2 = ra; bus.readRegisterRB_REG2 = rb;
    bus.readRegisterRC_REG2 = rc; bus.readUse_REG2 = u; bus.latency_REG2 = l;
  endtask

  task automatic clear_slots();
    set_slot1(0, 0, 0, 0, 0, 0, 3'b000, 1);
    set_slot2(0, 0, 0, 0, 0, 0, 3'b000, 1);
    bus.flush = 1'b0;
    bus.stall_ext = 1'b0;
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 2 ns later and
  // the counter/state 1 ns after the rising edge. Returns at the next falling edge.
  task automatic step(string tag);
    logic [2:0] exp;
    model_decide();
    #2;
    obs_i1 = bus.issue_EX1;
    obs_i2 = bus.issue_EX2;
    obs_s  = bus.stall_REG;
    exp = exp_q.pop_front();
    check_eq({tag, "_issue1"}, obs_i1, exp[2]);
    check_eq({tag, "_issue2"}, obs_i2, exp[1]);
    check_eq({tag, "_stall"},  obs_s,  exp[0]);
    @(posedge clk);
    model_commit();
    #1;
    check_eq({tag, "_stallcnt"}, stallCycles, m_stalls);
    check_eq({tag, "_split"},    split_active, m_split);
    @(negedge clk);
  endtask

  // Asserts reset wherever the caller is in the cycle, checks the outputs
  // clear at once, and releases on a falling edge.
  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("rst_issue1", bus.issue_EX1, 0);
    check_eq("rst_issue2", bus.issue_EX2, 0);
    check_eq("rst_stall",  bus.stall_REG, 0);
    check_eq("rst_split",  split_active, 0);
    check_eq("rst_stallcnt", stallCycles, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int at;
    reset = 1'b0;
    clear_slots();
    model_reset();
    #2;
    pulse_reset();

    // 1: independent pair, then a latency-2 consumer
    set_slot1(1, 1, 5, 0, 0, 0, 3'b000, 2);
    set_slot2(1, 0, 0, 1, 0, 0, 3'b001, 1);
    step("t1c0");
    check_eq("t1_pair_i1", obs_i1, 1);
    check_eq("t1_pair_i2", obs_i2, 1);
    set_slot1(1, 0, 0, 5, 0, 0, 3'b001, 1);
    set_slot2(0, 0, 0, 0, 0, 0, 3'b000, 1);
    step("t1c1");
    check_eq("t1_wait_i1", obs_i1, 0);
    check_eq("t1_wait_s", obs_s, 1);
    step("t1c2");
    check_eq("t1_go_i1", obs_i1, 1);
    check_eq("t1_stallcnt", stallCycles, 1);

    // 2: intra-pair RAW split on RB
    set_slot1(1, 1, 10, 0, 0, 0, 3'b000, 1);
    set_slot2(1, 0, 0, 0, 10, 0, 3'b010, 1);
    step("t2c0");
    check_eq("t2_c0_i2", obs_i2, 0);
    check_eq("t2_c0_split", split_active, 1);
    step("t2c1");
    check_eq("t2_c1_i2", obs_i2, 1);
    check_eq("t2_c1_split", split_active, 0);
    clear_slots();

    // 3: latency-7 producer then consumer
    pulse_reset();
    set_slot1(1, 1, 20, 0, 0, 0, 3'b000, 7);
    step("t3p");
    set_slot1(1, 0, 0, 0, 0, 20, 3'b100, 1);
    at = -1;
    for (int k = 1; k <= 20 && at < 0; k++) begin
      step("t3c");
      if (obs_i1) at = k;
    end
    check_eq("t3_issue_cycle", at, 7);
    check_eq("t3_stallcnt", stallCycles, 6);
    clear_slots();

    // 4: same, with a 3-cycle downstream freeze during the countdown
    pulse_reset();
    set_slot1(1, 1, 20, 0, 0, 0, 3'b000, 7);
    step("t4p");
    set_slot1(1, 0, 0, 0, 0, 20, 3'b100, 1);
    at = -1;
    for (int k = 1; k <= 25 && at < 0; k++) begin
      bus.stall_ext = (k >= 2 && k <= 4);
      step("t4c");
      if (obs_i1) at = k;
    end
    check_eq("t4_issue_cycle", at, 10);
    check_eq("t4_stallcnt", stallCycles, 9);
    clear_slots();

    // 5: flush while split; the producer count keeps running
    pulse_reset();
    set_slot1(1, 1, 30, 0, 0, 0, 3'b000, 4);
    set_slot2(1, 0, 0, 30, 0, 0, 3'b001, 1);
    step("t5c0");
    check_eq("t5_split", split_active, 1);
    bus.flush = 1'b1;
    step("t5f");
    check_eq("t5_f_i1", obs_i1, 0);
    check_eq("t5_f_i2", obs_i2, 0);
    check_eq("t5_f_s", obs_s, 0);
    check_eq("t5_f_split", split_active, 0);
    bus.flush = 1'b0;
    bus.valid_REG1 = 1'b0;
    at = -1;
    for (int k = 2; k <= 20 && at < 0; k++) begin
      step("t5c");
      if (obs_i2) at = k;
    end
    check_eq("t5_issue_cycle", at, 4);
    clear_slots();

    // 6: asynchronous reset mid-cycle while r5 is busy for 4 more cycles
    pulse_reset();
    set_slot1(1, 1, 5, 0, 0, 0, 3'b000, 5);
    step("t6p");
    set_slot1(1, 0, 0, 5, 0, 0, 3'b001, 1);
    #2;
    check_eq("t6_pre_stall", bus.stall_REG, 1);
    pulse_reset();
    step("t6c");
    check_eq("t6_post_i1", obs_i1, 1);
    check_eq("t6_post_stallcnt", stallCycles, 0);
    clear_slots();

    // randomized pairs over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      if (!(obs_s && $urandom_range(0, 3) != 0)) begin
        set_slot1($urandom_range(0, 5) != 0, $urandom_range(0, 1),
                  reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
                  reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), lat_t'($urandom_range(0, 7)));
        set_slot2($urandom_range(0, 5) != 0, $urandom_range(0, 1),
                  reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
                  reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), lat_t'($urandom_range(0, 7)));
      end
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.stall_ext = ($urandom_range(0, 9) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spu_issue_ctrl.md
Name: spu_issue_ctrl

Overview:
Dual-issue hazard and issue controller for the REG→EX boundary of the SPU pipeline. Each cycle it decides whether each of the two instructions held in the REG stage may advance into the REG/EX pipeline register, or whether a bubble is injected in its place. It keeps a per-register latency scoreboard of in-flight writes and detects intra-pair dependencies, splitting a pair when needed. It drives the stall for the upstream stages and the REG stage.

Parameters:
NUM_REGS, 128, architectural register count
REG_AW, 7, register address width
LAT_W, 3, producer latency field width (latency 1..7)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_REG1 / valid_REG2  in  1  slot holds a real instruction
regWriteEnable_REG1 / regWriteEnable_REG2  in  1  slot writes a register
writeRegister_REG1 / writeRegister_REG2  in  REG_AW  destination register
readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRC_REG1  in  REG_AW  slot-1 sources
readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRC_REG2  in  REG_AW  slot-2 sources
readUse_REG1 / readUse_REG2  in  3  source-used flags (bit0 RA, bit1 RB, bit2 RC)
latency_REG1 / latency_REG2  in  LAT_W  cycles until result is forwardable (0 treated as 1)
flush  in  1  branch redirect; discard REG contents
stall_ext  in  1  downstream freeze
issue_EX1 / issue_EX2  out  1  slot advances into EX (0 = load bubble: control/regWriteEnable zeroed)
stall_REG  out  1  hold fetch, decode and the REG-stage register
split_active  out  1  state == SPLIT
stallCycles  out  CNT_W  saturating count of cycles with stall_REG = 1

Behaviour:
- Reset (asynchronous): state = PAIR; all scoreboard counters = 0; stallCycles = 0. While reset is asserted: issue_EX1 = issue_EX2 = 0, stall_REG = 0.
- Scoreboard: one LAT_W counter per register. cnt[r] != 0 means the result is not yet forwardable.
- Source hazard, slot i (srcHaz_i): any used source s with cnt[s] != 0.
- Write-after-write hazard, slot i (wawHaz_i): regWriteEnable_i and cnt[dest_i] > (lat_i − 1).
- haz_i = srcHaz_i | wawHaz_i.
- Intra-pair conflict (intra): valid1 and regWriteEnable1, and either
  - some used slot-2 source equals dest1, or
  - regWriteEnable2 and dest2 == dest1.
- In SPLIT state, slot 1 is treated as invalid, so intra = 0.
- Issue decisions are combinational from the current inputs and the registered state/scoreboard. There is zero added latency.
  - issue1 = v1 & !haz1 & !stall_ext & !flush
  - issue2 = v2 & !haz2 & !intra & (issue1 | !v1) & !stall_ext & !flush
  - Here v1 = valid_REG1 & (state == PAIR), and v2 = valid_REG2.
- In-order rule: slot 2 never issues ahead of a valid slot 1.
- stall_REG = !flush & ((v1 & !issue1) | (v2 & !issue2)).
- State transitions (FSM: PAIR, SPLIT):
  - PAIR → SPLIT when issue1 & v2 & !issue2.
  - SPLIT → PAIR when issue2.
  - Any state → PAIR on flush; flush has priority.
- Scoreboard update on each clock edge:
  - stall_ext = 1: all counters hold, no loads.
  - Otherwise: every nonzero counter decrements by 1. Then each issuing slot with regWriteEnable loads cnt[dest] = lat − 1. A load overrides the decrement for that register.
  - Both slots never load the same register in one cycle; the intra WAW check guarantees this.
  - Flush: counters still decrement (in-flight writes still complete); no loads occur because nothing issues.
- Latency semantics: latency 1 allows back-to-back forwarding. Latency L forces L−1 bubble cycles for a dependent instruction.
- stallCycles: +1 on each edge where stall_REG = 1; saturates at all-ones.

Decomposition:
- Package spu_pipe_pkg holds:
  - REG_AW, LAT_W, NUM_REGS
  - the readUse bit indices (USE_RA = 0, USE_RB = 1, USE_RC = 2)
  - the state enum issue_state_t {PAIR, SPLIT}
- Sub-module spu_scoreboard provides:
  - the counter array
  - 8 combinational read ports: 6 sources and 2 destinations
  - 2 load ports (enable, address, value)
  - a hold input
- spu_issue_ctrl holds the hazard logic, the FSM and the performance counter.

Test Plan:
1. Reset, then slot 1 writes r5 with latency 2 and slot 2 reads r1 (independent). Result: both issue in cycle 0. In cycle 1, a slot-1 reader of r5 sees stall_REG = 1 and issue_EX1 = 0. In cycle 2 it issues; stallCycles = 1.
2. Slot 1 writes r10 with latency 1 and slot 2 reads r10 on RB. Cycle 0: issue_EX1 = 1, issue_EX2 = 0, stall_REG = 1, split_active goes to 1. Cycle 1: issue_EX2 = 1 and the state returns to PAIR.
3. Load writes r20 with latency 7, followed by a consumer of r20. Result: 6 stall cycles, the consumer issues 7 cycles after the producer, and stallCycles = 6.
4. Same as scenario 3, but stall_ext is held for 3 cycles during the countdown. Result: counters freeze, and the consumer issues 10 cycles after the producer.
5. In SPLIT state, assert flush for 1 cycle. Result: issue_EX1 = issue_EX2 = 0 and stall_REG = 0; the next state is PAIR. The earlier producer's counter keeps decrementing.
6. Pulse reset asynchronously mid-clock while cnt[r5] = 4. Result: outputs clear immediately, all counters = 0, and stallCycles = 0. After release, a reader of r5 issues with no stall.
